// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit (lsu_mem_if).
// State encoding, decoder store/load type codes, store lane steering and
// the alignment/reserved-code fault predicate used when LSU_MISALIGN_CHECK_EN
// is defined.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Store truncation type: funct3[1:0] of SB/SH/SW.
    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b10;

    // Load extension type: funct3 of LB/LH/LW/LBU/LHU.
    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_lanes_t;

    // Byte enables and replicated write data for a store; a reserved store
    // type falls through to a full-word write.
    function automatic store_lanes_t store_steer(input logic [1:0]  trnc,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] wdata);
        store_lanes_t s;
        case (trnc)
            ST_B: begin
                s.be    = 4'b0001 << off;
                s.wdata = {4{wdata[7:0]}};
            end
            ST_H: begin
                s.be    = off[1] ? 4'b1100 : 4'b0011;
                s.wdata = {2{wdata[15:0]}};
            end
            default: begin
                s.be    = 4'b1111;
                s.wdata = wdata;
            end
        endcase
        return s;
    endfunction

    // True when an access is misaligned for its size or uses a reserved code.
    function automatic logic lsu_fault(input logic       we,
                                       input logic [1:0] off,
                                       input logic [1:0] trnc,
                                       input logic [2:0] ext);
        logic f;
        if (we) begin
            case (trnc)
                ST_B:    f = 1'b0;
                ST_H:    f = off[0];
                ST_W:    f = (off != 2'b00);
                default: f = 1'b1;
            endcase
        end else begin
            case (ext)
                LD_B, LD_BU: f = 1'b0;
                LD_H, LD_HU: f = off[0];
                LD_W:        f = (off != 2'b00);
                default:     f = 1'b1;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result extraction: picks the addressed byte/halfword out of a bus
// word and sign- or zero-extends it. Reserved load codes pass the word through.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  ext_type,
    output logic [31:0] rdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select then extension, purely combinational.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via a default first) so no latch is inferred.
        byte_v = mem_rdata[7:0];
        rdata  = mem_rdata;
        case (offset)
            2'd0:    byte_v = mem_rdata[7:0];
            2'd1:    byte_v = mem_rdata[15:8];
            2'd2:    byte_v = mem_rdata[23:16];
            default: byte_v = mem_rdata[31:24];
        endcase
        half_v = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ext_type)
            LD_B:    rdata = {{24{byte_v[7]}}, byte_v};
            LD_H:    rdata = {{16{half_v[15]}}, half_v};
            LD_BU:   rdata = {24'h0, byte_v};
            LD_HU:   rdata = {16'h0, half_v};
            default: rdata = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// RV32I load/store unit: one access at a time over a req/ready data-memory
// bus, with byte-lane steering, byte enables and load extension.
// Optional build macro LSU_MISALIGN_CHECK_EN: fault misaligned or
// reserved-type requests in IDLE without issuing a bus cycle.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              acc_valid,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic [1:0]        acc_trnc,
    input  logic [2:0]        acc_ext,
    output logic              acc_stall,
    output logic              acc_done,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("lsu_mem_if: DATA_W must be 32 for RV32I");
    end

    lsu_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        ext_q, ext_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] ext_rdata;
    store_lanes_t      lanes;
`ifdef LSU_MISALIGN_CHECK_EN
    logic              err_q, err_d;
`endif

    assign lanes = store_steer(acc_trnc, acc_addr[1:0], acc_wdata);

    lsu_load_ext u_load_ext (
        .mem_rdata (mem_rdata),
        .offset    (off_q),
        .ext_type  (ext_q),
        .rdata     (ext_rdata)
    );

    // Next-state logic: accept in IDLE, hold the bus until ready, pulse done.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        off_d       = off_q;
        ext_d       = ext_q;
        rdata_d     = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (acc_valid) begin
                    off_d = acc_addr[1:0];
                    ext_d = acc_ext;
`ifdef LSU_MISALIGN_CHECK_EN
                    err_d = lsu_fault(acc_we, acc_addr[1:0], acc_trnc, acc_ext);
`endif
                    mem_we_d    = acc_we;
                    mem_addr_d  = {acc_addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = acc_we ? lanes.be : 4'b1111;
                    mem_wdata_d = acc_we ? lanes.wdata : '0;
                    mem_req_d   = 1'b1;
                    state_d     = BUS;
`ifdef LSU_MISALIGN_CHECK_EN
                    if (err_d) begin
                        // A faulted request never reaches the bus.
                        mem_req_d = 1'b0;
                        rdata_d   = '0;
                        state_d   = RESP;
                    end
`endif
                end
            end
            BUS: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    rdata_d   = mem_we_q ? '0 : ext_rdata;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
                err_d   = 1'b0;
`endif
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and bus registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            off_q       <= 2'b00;
            ext_q       <= 3'b000;
            rdata_q     <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            off_q       <= off_d;
            ext_q       <= ext_d;
            rdata_q     <= rdata_d;
`ifdef LSU_MISALIGN_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

    // Stall is low in RESP so the core advances together with acc_done.
    assign acc_stall = (acc_valid && state_q == IDLE) || (state_q == BUS);
    assign acc_done  = (state_q == RESP);
    assign acc_rdata = rdata_q;
`ifdef LSU_MISALIGN_CHECK_EN
    assign acc_err   = err_q && (state_q == RESP);
`else
    assign acc_err   = 1'b0;
`endif

endmodule
